// File: rtl/decode_stage_if.sv
// Instruction handshake between the fetch side and the decode stage.
// The master drives the instruction word and valid; the decode stage answers with ready.
interface decode_stage_if;
   logic [15:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;

   modport master (output instr_in, output instr_valid, input  instr_ready);
   modport slave  (input  instr_in, input  instr_valid, output instr_ready);
endinterface

// File: rtl/decode_stage.sv
// Decode and operand fetch ahead of the 16-bit ALU: 8x16 register file, one-bubble
// RAW stall against the op in the ALU, forwarding from the ALU's registered result.
module decode_stage #(
   parameter int NREG = 8
) (
   input  logic           clk,
   input  logic           reset,
   decode_stage_if.slave  up,
   input  logic [15:0]    ans_ex,
   input  logic           wb_en,
   input  logic [2:0]     wb_addr,
   input  logic [15:0]    wb_data,
   output logic [5:0]     op_dec,
   output logic [15:0]    A,
   output logic [15:0]    B,
   output logic [2:0]     rd_ex,
   output logic           we_ex,
   output logic           valid_ex
);

   localparam logic [5:0] OP_HOLD = 6'b010000;

   logic [15:0] rf_q [NREG];
   logic [15:0] rf_d [NREG];
   logic [5:0]  op_dec_q, op_dec_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [2:0]  rd_ex_q, rd_ex_d;
   logic        we_ex_q, we_ex_d;
   logic        valid_ex_q, valid_ex_d;
   logic [2:0]  ex2_rd_q, ex2_rd_d;
   logic        ex2_we_q, ex2_we_d;

   logic [5:0]  opcode;
   logic [2:0]  rd, rs, rt;
   logic [3:0]  imm4;
   logic        is_imm;
   logic        writes_rd;
   logic        hazard;
   logic        issue;
   logic [15:0] opnd_a, opnd_b;

   // Forwarded ALU result beats the write-back bypass, which beats the array.
   function automatic logic [15:0] fetch(
      input logic [2:0]  idx,
      input logic [15:0] rf_val,
      input logic        fwd_we,
      input logic [2:0]  fwd_rd,
      input logic [15:0] fwd_val,
      input logic        byp_en,
      input logic [2:0]  byp_addr,
      input logic [15:0] byp_data
   );
      logic [15:0] val;
      if (idx == 3'd0)
         val = 16'h0000;
      else if (fwd_we && (fwd_rd == idx))
         val = fwd_val;
      else if (byp_en && (byp_addr == idx))
         val = byp_data;
      else
         val = rf_val;
      return val;
   endfunction

   assign opcode = up.instr_in[15:10];
   assign rd     = up.instr_in[9:7];
   assign rs     = up.instr_in[6:4];
   assign rt     = up.instr_in[3:1];
   assign imm4   = up.instr_in[3:0];
   assign is_imm = (opcode[5:3] == 3'b001);

   always_comb begin
      writes_rd = (rd != 3'd0);
      if (opcode inside {6'b010000, 6'b010001, 6'b010111, 6'b011000})
         writes_rd = 1'b0;
   end

   // rd_ex_q/we_ex_q double as the tracking entry for the op now in the ALU.
   assign hazard = up.instr_valid && we_ex_q &&
                   ((rd_ex_q == rs) || (!is_imm && (rd_ex_q == rt)));
   assign issue  = up.instr_valid && !hazard;
   assign up.instr_ready = !hazard;

   assign opnd_a = fetch(rs, rf_q[rs], ex2_we_q, ex2_rd_q, ans_ex, wb_en, wb_addr, wb_data);
   assign opnd_b = fetch(rt, rf_q[rt], ex2_we_q, ex2_rd_q, ans_ex, wb_en, wb_addr, wb_data);

   always_comb begin
      rf_d = rf_q;
      if (wb_en && (wb_addr != 3'd0))
         rf_d[wb_addr] = wb_data;

      ex2_rd_d = rd_ex_q;
      ex2_we_d = we_ex_q;

      op_dec_d   = OP_HOLD;
      a_d        = 16'h0000;
      b_d        = 16'h0000;
      rd_ex_d    = 3'd0;
      we_ex_d    = 1'b0;
      valid_ex_d = 1'b0;
      if (issue) begin
         op_dec_d   = opcode;
         a_d        = opnd_a;
         b_d        = is_imm ? {{12{imm4[3]}}, imm4} : opnd_b;
         rd_ex_d    = rd;
         we_ex_d    = writes_rd;
         valid_ex_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= 16'h0000;
         op_dec_q   <= OP_HOLD;
         a_q        <= 16'h0000;
         b_q        <= 16'h0000;
         rd_ex_q    <= 3'd0;
         we_ex_q    <= 1'b0;
         valid_ex_q <= 1'b0;
         ex2_rd_q   <= 3'd0;
         ex2_we_q   <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         op_dec_q   <= op_dec_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rd_ex_q    <= rd_ex_d;
         we_ex_q    <= we_ex_d;
         valid_ex_q <= valid_ex_d;
         ex2_rd_q   <= ex2_rd_d;
         ex2_we_q   <= ex2_we_d;
      end
   end

   assign op_dec   = op_dec_q;
   assign A        = a_q;
   assign B        = b_q;
   assign rd_ex    = rd_ex_q;
   assign we_ex    = we_ex_q;
   assign valid_ex = valid_ex_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal cases, then random programs checked
// against an architectural model that plays the ALU and write-back stages.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ans_ex, wb_data, A, B;
   logic        wb_en;
   logic [2:0]  wb_addr, rd_ex;
   logic [5:0]  op_dec;
   logic        we_ex, valid_ex;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_stage_if dif ();

   decode_stage #(.NREG(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .up       (dif),
      .ans_ex   (ans_ex),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .op_dec   (op_dec),
      .A        (A),
      .B        (B),
      .rd_ex    (rd_ex),
      .we_ex    (we_ex),
      .valid_ex (valid_ex)
   );

   typedef struct packed {
      logic        we;
      logic [2:0]  rd;
      logic [15:0] res;
   } slot_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] mk(input logic [5:0] op, input int rd, input int rs, input int rt);
      logic [2:0] d, s, t;
      d = rd[2:0];
      s = rs[2:0];
      t = rt[2:0];
      return {op, d, s, t, 1'b0};
   endfunction

   function automatic logic [15:0] mki(input logic [5:0] op, input int rd, input int rs, input logic [3:0] imm);
      logic [2:0] d, s;
      d = rd[2:0];
      s = rs[2:0];
      return {op, d, s, imm};
   endfunction

   function automatic bit op_writes(input logic [5:0] op, input logic [2:0] rd);
      if (rd == 3'd0) return 1'b0;
      if (op == 6'd16 || op == 6'd17 || op == 6'd23 || op == 6'd24) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] gen_instr();
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)
         op = 6'd8 + 6'($urandom_range(0, 7));
      else if (sel == 3) begin
         case ($urandom_range(0, 3))
            0: op = 6'd16;
            1: op = 6'd17;
            2: op = 6'd23;
            default: op = 6'd24;
         endcase
      end else
         op = 6'($urandom_range(0, 63));
      return {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
   endfunction

   task automatic chk_bubble(input string tag);
      chk({tag, "_op"}, 16'(op_dec), 16'h0010);
      chk({tag, "_valid"}, 16'(valid_ex), 16'h0);
      chk({tag, "_we"}, 16'(we_ex), 16'h0);
      chk({tag, "_A"}, A, 16'h0);
      chk({tag, "_B"}, B, 16'h0);
   endtask

   task automatic directed;
      dif.instr_valid = 1'b0; dif.instr_in = 16'h0;
      wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0; ans_ex = 16'h0;
      reset = 1'b0;
      #12;
      chk_bubble("rst");
      chk("rst_rd", 16'(rd_ex), 16'h0);
      chk("rst_ready", 16'(dif.instr_ready), 16'h1);
      @(negedge clk); reset = 1'b1;
      tick;

      // plain issue
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005; tick;
      wb_addr = 3'd2; wb_data = 16'h0003; tick;
      wb_en = 1'b0; tick; tick;
      dif.instr_valid = 1'b1; dif.instr_in = mk(6'd0, 3, 1, 2);
      #1 chk("add_ready", 16'(dif.instr_ready), 16'h1);
      tick;
      chk("add_A", A, 16'h0005); chk("add_B", B, 16'h0003);
      chk("add_rd", 16'(rd_ex), 16'h3); chk("add_we", 16'(we_ex), 16'h1);
      chk("add_valid", 16'(valid_ex), 16'h1); chk("add_op", 16'(op_dec), 16'h0);

      // immediate, imm4 = E -> -2
      dif.instr_in = mki(6'b001000, 6, 1, 4'hE);
      #1 chk("imm_ready", 16'(dif.instr_ready), 16'h1);
      tick;
      chk("imm_A", A, 16'h0005); chk("imm_B", B, 16'hFFFE); chk("imm_op", 16'(op_dec), 16'h0008);

      // back-to-back dependence: one bubble, then forward
      dif.instr_in = mk(6'd0, 3, 1, 2); tick;
      dif.instr_in = mk(6'd0, 7, 3, 1); ans_ex = 16'h0AAA;
      #1 chk("stall_ready", 16'(dif.instr_ready), 16'h0);
      tick;
      chk_bubble("stall");
      ans_ex = 16'h0042;
      #1 chk("stall_ready2", 16'(dif.instr_ready), 16'h1);
      tick;
      chk("fwd1_A", A, 16'h0042); chk("fwd1_B", B, 16'h0005);
      chk("fwd1_rd", 16'(rd_ex), 16'h7); chk("fwd1_valid", 16'(valid_ex), 16'h1);

      // distance-2 forwarding
      dif.instr_in = mk(6'd0, 4, 1, 2); ans_ex = 16'h0; tick;
      dif.instr_in = mk(6'd1, 5, 2, 1); tick;
      dif.instr_in = mk(6'd2, 6, 1, 4); ans_ex = 16'h1234;
      #1 chk("d2_ready", 16'(dif.instr_ready), 16'h1);
      tick;
      chk("d2_A", A, 16'h0005); chk("d2_B", B, 16'h1234);

      // write-back bypass and R0
      dif.instr_valid = 1'b0; ans_ex = 16'h0; tick; tick;
      dif.instr_valid = 1'b1; dif.instr_in = mk(6'b010111, 1, 5, 0);
      wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
      tick;
      chk("byp_A", A, 16'hBEEF); chk("byp_B", B, 16'h0);
      chk("byp_we", 16'(we_ex), 16'h0); chk("byp_valid", 16'(valid_ex), 16'h1);
      dif.instr_valid = 1'b0; wb_addr = 3'd0; wb_data = 16'hFFFF; tick;
      wb_en = 1'b0; dif.instr_valid = 1'b1; dif.instr_in = mk(6'd0, 3, 0, 5); tick;
      chk("r0_A", A, 16'h0); chk("r5_B", B, 16'hBEEF);

      // reset during a stall
      dif.instr_in = mk(6'd0, 2, 3, 0);
      #1 chk("rs_stall_ready", 16'(dif.instr_ready), 16'h0);
      reset = 1'b0;
      #1;
      chk_bubble("mid_rst");
      chk("mid_rst_rd", 16'(rd_ex), 16'h0);
      chk("mid_rst_ready", 16'(dif.instr_ready), 16'h1);
      dif.instr_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      dif.instr_valid = 1'b1; dif.instr_in = mk(6'd0, 2, 1, 0); ans_ex = 16'hFFFF;
      tick;
      chk("post_rst_R1", A, 16'h0); chk("post_rst_valid", 16'(valid_ex), 16'h1);
      dif.instr_valid = 1'b0; ans_ex = 16'h0;
   endtask

   task automatic random_run(input int cycles);
      logic [15:0] arch [8];
      slot_t ex_s, ans_s, wb_s, nxt;
      logic        have;
      logic [15:0] cur;
      logic [5:0]  op;
      logic [2:0]  rd, rs, rt;
      logic [3:0]  imm;
      bit          imm_op, stall, issued;
      logic [15:0] exp_a, exp_b;

      reset = 1'b0; #3;
      @(negedge clk); reset = 1'b1;
      tick;
      for (int i = 0; i < 8; i++) arch[i] = 16'h0;
      ex_s = '0; ans_s = '0; wb_s = '0; have = 1'b0; cur = 16'h0;

      for (int c = 0; c < cycles; c++) begin
         if (!have && $urandom_range(0, 9) < 8) begin
            cur = gen_instr();
            have = 1'b1;
         end
         dif.instr_valid = have;
         dif.instr_in    = have ? cur : 16'($urandom);
         ans_ex  = ans_s.res;
         wb_en   = wb_s.we;
         wb_addr = wb_s.rd;
         wb_data = wb_s.res;

         op = cur[15:10]; rd = cur[9:7]; rs = cur[6:4]; rt = cur[3:1]; imm = cur[3:0];
         imm_op = (op >= 6'd8) && (op < 6'd16);
         stall  = have && ex_s.we && (ex_s.rd == rs || (!imm_op && ex_s.rd == rt));
         issued = have && !stall;
         #1 chk("rnd_ready", 16'(dif.instr_ready), 16'(!stall));

         exp_a = arch[rs];
         exp_b = imm_op ? ((imm >= 4'd8) ? 16'(imm) + 16'hFFF0 : 16'(imm)) : arch[rt];
         nxt.we  = issued && op_writes(op, rd);
         nxt.rd  = issued ? rd : 3'd0;
         nxt.res = 16'($urandom);

         tick;
         if (issued) begin
            chk("rnd_op", 16'(op_dec), 16'(op));
            chk("rnd_valid", 16'(valid_ex), 16'h1);
            chk("rnd_we", 16'(we_ex), 16'(nxt.we));
            chk("rnd_rd", 16'(rd_ex), 16'(rd));
            chk("rnd_A", A, exp_a);
            chk("rnd_B", B, exp_b);
            if (nxt.we) arch[rd] = nxt.res;
            have = 1'b0;
         end else
            chk_bubble("rnd_bubble");
         wb_s  = ans_s;
         ans_s = ex_s;
         ex_s  = nxt;
      end
      dif.instr_valid = 1'b0; wb_en = 1'b0;
   endtask

   initial begin
      directed();
      random_run(3000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
